perm_rr_sched: RTL and testbench
================================

Name: perm_rr_sched

Overview:
- Round-robin scheduler sharing one registered bit-reversal permutation unit among NREQ requesters.
- Each requester presents an N-bit vector. The scheduler grants one requester per beat, reverses the granted vector (q[i] = d[N-1-i], built with a for loop in an always block), and emits it with the winner's ID.
- Bursts are bounded per owner so that sharing stays fair.
- Sits between requester-side datapaths and one downstream consumer that uses a valid/ready handshake.

Parameters:
- N, 8, vector width in bits (>=1).
- NREQ, 4, number of requesters (>=2).
- BURST, 4, maximum consecutive beats per grant tenure (>=1).
- IDW, derived as $clog2(NREQ), requester ID width; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held until granted.
- req_data  input  NREQ*N  packed vectors; requester k occupies bits [k*N +: N].
- gnt  output  NREQ  one-hot combinational grant; a beat transfers when req[k] & gnt[k].
- out_data  output  N  reversed vector of the accepted beat.
- out_id  output  IDW  index of the requester that supplied out_data.
- out_valid  output  1  out_data/out_id are valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- busy  output  1  high while state is OWN.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_id=0.
  - ptr=0, owner=0, cnt=0, state=IDLE.
  - gnt=0 combinationally while rst=1.
  - Any in-flight beat is discarded; no partial output after reset release.
- slot_free = !out_valid | out_ready. gnt is all-zero whenever slot_free=0; this is the backpressure path.
- State IDLE:
  - Scan k = 0..NREQ-1 over index (ptr+k) mod NREQ. The first set req wins (for loop in always block).
  - If slot_free and a winner exists: assert gnt[winner] the same cycle.
  - Next edge: owner=winner, cnt=1, state=OWN; or state stays IDLE with ptr=(winner+1) mod NREQ if BURST==1.
  - No req set: gnt=0 and state holds.
- State OWN:
  - gnt[owner]=req[owner] & slot_free. On a transfer, cnt increments.
  - Release at the edge where either:
    - a transfer makes cnt reach BURST, or
    - req[owner]=0 while slot_free.
  - On release: state=IDLE, ptr=(owner+1) mod NREQ.
  - A stalled owner (slot_free=0) keeps ownership regardless of req.
- Datapath (latency 1 cycle from transfer edge to out_valid):
  - On transfer: out_data[i] <= req_data[win*N + N-1-i] for all i, out_id <= win, out_valid <= 1.
  - Else if out_ready: out_valid <= 0. out_data/out_id hold their last value.
  - Transfer and drain in the same cycle: new data loads, out_valid stays 1. Full throughput is one beat per cycle.
- Arithmetic rules:
  - ptr wrap is modulo NREQ, including non-power-of-2 NREQ (next after NREQ-1 is 0).
  - cnt width is $clog2(BURST+1).
- Boundary conditions:
  - All req high: service order is ptr, ptr+1, ... with BURST beats each when req stays high.
  - Single requester: it is re-granted immediately after each release; no idle bubble, because IDLE grants the same cycle.
  - Winner drops req before transfer: no beat is taken. In IDLE it is simply not selected; in OWN, release occurs.
- busy = (state==OWN).

Optional Feature:
- Macro: PERM_RR_SCHED_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit), registered with out_data, equal to ^out_data; reset 0.
  - Adds input in_err_inj (1 bit); when high on a transfer, out_par is inverted. This exists for checker testing.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset mid-burst: assert rst while out_valid=1 and state=OWN -> out_valid=0, out_data=0, busy=0 immediately. After release with req=4'b0001, first out_id=0.
- Reversal, N=8: req[2]=1, data2=8'b0000_0001, out_ready=1 -> gnt=4'b0100 the same cycle; next cycle out_data=8'b1000_0000, out_id=2, out_valid=1.
- Fairness, BURST=4: req=4'b1111 held, out_ready=1 -> out_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,...
- Early release: req[1] drops after 2 accepted beats while req[3]=1 -> busy falls, ptr=2, next grant goes to requester 3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles -> gnt=0, out_data/out_id stable. out_ready=1 -> drain and new load in the same cycle, out_valid stays 1.
- Parity, macro defined: out_data=8'b1011_0000 -> out_par=1. Same beat with in_err_inj=1 -> out_par=0.

Source files
------------

// File: rtl/perm_rr_sched.sv
// rtl/perm_rr_sched.sv - round-robin scheduler feeding one registered bit-reversal unit
// Optional parity output/error-injection input enabled by defining PERM_RR_SCHED_PARITY_EN.
module perm_rr_sched #(
  parameter int N     = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*N-1:0]          req_data,
  output logic [NREQ-1:0]            gnt,
  output logic [N-1:0]               out_data,
  output logic [$clog2(NREQ)-1:0]    out_id,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef PERM_RR_SCHED_PARITY_EN
  output logic                       out_par,
  input  logic                       in_err_inj,
`endif
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             out_valid_q;
  logic [N-1:0]     out_data_q;
  logic [IDW-1:0]   out_id_q;

  logic             slot_free;
  logic             found;
  logic [IDW-1:0]   winner;
  logic             transfer;
  logic [IDW-1:0]   win_id;
  logic [N-1:0]     lane [NREQ];
  logic [N-1:0]     sel_vec;
  logic [N-1:0]     rev_vec;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction

  assign slot_free = !out_valid_q | out_ready;

  // Rotating priority: the first requester at or after ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (slot_free && found) begin
          if (BURST == 1) begin
            ptr_d = next_id(winner);
          end else begin
            state_d = OWN;
            owner_d = winner;
            cnt_d   = CW'(1);
          end
        end
      end
      OWN: begin
        // A stalled owner holds its tenure whatever its request does.
        if (slot_free) begin
          if (req[owner_q] && (cnt_q + 1'b1 != CW'(BURST))) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
            ptr_d   = next_id(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (!rst && slot_free) begin
      if (state_q == IDLE) begin
        if (found) gnt[winner] = 1'b1;
      end else begin
        gnt[owner_q] = req[owner_q];
      end
    end
  end

  assign busy     = (state_q == OWN);
  assign transfer = |(req & gnt);
  assign win_id   = (state_q == IDLE) ? winner : owner_q;

  always_comb begin
    for (int k = 0; k < NREQ; k++) lane[k] = req_data[k*N +: N];
  end

  assign sel_vec = lane[win_id];

  always_comb begin
    rev_vec = '0;
    for (int i = 0; i < N; i++) rev_vec[i] = sel_vec[N-1-i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rev_vec;
      out_id_q    <= win_id;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PERM_RR_SCHED_PARITY_EN
  logic out_par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par_q <= 1'b0;
    end else if (transfer) begin
      out_par_q <= (^rev_vec) ^ in_err_inj;
    end
  end

  assign out_par = out_par_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_perm_rr_sched.sv
// tb/tb_perm_rr_sched.sv - directed self-checking bench for perm_rr_sched
// Parity checks are built only when PERM_RR_SCHED_PARITY_EN is defined.
module tb_perm_rr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef PERM_RR_SCHED_PARITY_EN
  logic        out_par;
  logic        in_err_inj;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_rev [4];

  perm_rr_sched #(.N(8), .NREQ(4), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PERM_RR_SCHED_PARITY_EN
    .out_par   (out_par),
    .in_err_inj(in_err_inj),
`endif
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_rev[0] = 8'h80;
    exp_rev[1] = 8'hC0;
    exp_rev[2] = 8'hF0;
    exp_rev[3] = 8'h48;
`ifdef PERM_RR_SCHED_PARITY_EN
    in_err_inj = 1'b0;
`endif
    rst = 1'b1; req = 4'b1111; req_data = '0; out_ready = 1'b1;
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_id", out_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    req = 4'b0000;

    tick();
    rst = 1'b0;
    req = 4'b0100;
    req_data[23:16] = 8'b0000_0001;
    #1;
    chk("rev_gnt", gnt, 4'b0100);
    chk("rev_busy_pre", busy, 1'b0);
    tick();
    chk("rev_data", out_data, 8'b1000_0000);
    chk("rev_id", out_id, 2'd2);
    chk("rev_valid", out_valid, 1'b1);
    chk("rev_busy", busy, 1'b1);
    req = 4'b0000;
    #1;
    chk("rev_drop_gnt", gnt, 4'b0000);
    tick();
    chk("rev_drain_valid", out_valid, 1'b0);
    chk("rev_hold_data", out_data, 8'h80);
    chk("rev_release_busy", busy, 1'b0);

    req_data = {8'h12, 8'h0F, 8'h03, 8'h01};
    req = 4'b1111;
    tick();
    chk("mid_pre_valid", out_valid, 1'b1);
    chk("mid_pre_id", out_id, 2'd3);
    chk("mid_pre_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_gnt", gnt, 4'b0000);
    req = 4'b0001;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", gnt, 4'b0001);
    tick();
    chk("post_rst_id", out_id, 2'd0);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, exp_rev[0]);

    req = 4'b1111;
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk($sformatf("fair_id_%0d", j), out_id, (j / 4) % 4);
      chk($sformatf("fair_data_%0d", j), out_data, exp_rev[(j / 4) % 4]);
      chk($sformatf("fair_valid_%0d", j), out_valid, 1'b1);
    end

    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    #1;
    chk("early_gnt0", gnt, 4'b0010);
    tick();
    chk("early_id1", out_id, 2'd1);
    tick();
    chk("early_id2", out_id, 2'd1);
    chk("early_valid2", out_valid, 1'b1);
    req = 4'b1000;
    #1;
    chk("early_drop_gnt", gnt, 4'b0000);
    chk("early_drop_busy", busy, 1'b1);
    tick();
    chk("early_rel_busy", busy, 1'b0);
    chk("early_rel_valid", out_valid, 1'b0);
    chk("early_next_gnt", gnt, 4'b1000);
    tick();
    chk("early_next_id", out_id, 2'd3);
    chk("early_next_valid", out_valid, 1'b1);

    out_ready = 1'b0;
    #1;
    chk("bp_gnt0", gnt, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_gnt_%0d", c), gnt, 4'b0000);
      chk($sformatf("bp_valid_%0d", c), out_valid, 1'b1);
      chk($sformatf("bp_id_%0d", c), out_id, 2'd3);
      chk($sformatf("bp_data_%0d", c), out_data, 8'h48);
      chk($sformatf("bp_busy_%0d", c), busy, 1'b1);
    end
    req_data[31:24] = 8'h80;
    out_ready = 1'b1;
    #1;
    chk("bp_resume_gnt", gnt, 4'b1000);
    tick();
    chk("bp_load_valid", out_valid, 1'b1);
    chk("bp_load_data", out_data, 8'h01);
    chk("bp_load_id", out_id, 2'd3);
    req = 4'b0000;
    tick();
    chk("bp_final_valid", out_valid, 1'b0);
    chk("bp_final_busy", busy, 1'b0);

`ifdef PERM_RR_SCHED_PARITY_EN
    req = 4'b0001;
    req_data[7:0] = 8'b0000_1101;
    tick();
    chk("par_data", out_data, 8'b1011_0000);
    chk("par_clean", out_par, 1'b1);
    in_err_inj = 1'b1;
    tick();
    chk("par_inj_data", out_data, 8'b1011_0000);
    chk("par_inj", out_par, 1'b0);
    in_err_inj = 1'b0;
    req = 4'b0000;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
